// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - credit-based instruction fetch with in-order tag queue and redirect flush
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req_valid,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_req_ready,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       halt_req,
  output logic                       halted,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [XLEN-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0] buf_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_C1 = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTING, S_HALTED} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count_q, count_d, outst_q, outst_d, discard_q, discard_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [AW-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] tag_mem   [DEPTH];

  logic            req_fire, push, pop;
  logic [CW:0]     credit_used;

  // Outstanding requests reserve buffer slots, so a response always finds room.
  assign credit_used    = {1'b0, outst_q} + {1'b0, count_q};
  assign imem_req_valid = (state_q == S_RUN) && !halt_req && (credit_used < DEPTH_C1);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign out_valid = (count_q != '0);
  assign out_instr = instr_mem[head_q];
  assign out_pc    = pc_mem[head_q];
  assign pop       = out_valid && out_ready;
  assign buf_count = count_q;
  assign halted    = (state_q == S_HALTED);

  assign push = imem_rsp_valid && !redirect_valid && (discard_q == '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
    discard_d  = discard_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    head_d     = pop  ? head_q + AW'(1) : head_q;
    tail_d     = push ? tail_q + AW'(1) : tail_q;
    tag_wr_d   = req_fire ? tag_wr_q + AW'(1) : tag_wr_q;
    tag_rd_d   = imem_rsp_valid ? tag_rd_q + AW'(1) : tag_rd_q;

    if (redirect_valid) begin
      // Every request still in flight after this cycle belongs to the old path.
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      discard_d  = outst_d;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = S_RUN;
      S_RUN:     if (halt_req) state_d = S_HALTING;
      S_HALTING: begin
        if (!halt_req)          state_d = S_RUN;
        else if (outst_d == '0) state_d = S_HALTED;
      end
      S_HALTED:  if (!halt_req) state_d = S_RUN;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_q] <= imem_rsp_data;
      pc_mem[tail_q]    <= tag_mem[tag_rd_q];
    end
    if (req_fire) tag_mem[tag_wr_q] <= fetch_pc_q;
  end

  assert property (@(posedge clk) disable iff (!reset)
    (outst_q <= DEPTH_C) && (discard_q <= DEPTH_C));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized and directed checks of instr_fetch_unit against a program-order model
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  buf_count;

  instr_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .halted(halted),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int unsigned rc; } mreq_t;
  mreq_t       mem_q[$];
  logic [31:0] req_log[$];
  logic [31:0] pops_log[$];

  int unsigned n_checks = 0, n_errors = 0;
  int unsigned cyc = 0, n_req = 0, n_pops = 0, last_rsp_cyc = 0;
  int unsigned lat_min = 1, lat_max = 1, rsp_pct = 100;
  logic        t_ready = 0, t_out_ready = 0, t_redirect = 0, t_halt = 0;
  logic [31:0] t_redirect_pc = '0;
  logic [31:0] m_fetch_pc, m_exp_pc;
  logic        prev_redirect = 0;
  logic        obs_req_valid, obs_halted;
  logic [2:0]  obs_count;

  function automatic logic [31:0] ifn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    redirect_valid = 0; redirect_pc = '0; halt_req = 0; out_ready = 0;
    t_ready = 0; t_out_ready = 0; t_redirect = 0; t_halt = 0;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_buf_count", buf_count, 0);
    mem_q.delete(); req_log.delete(); pops_log.delete();
    m_fetch_pc = 32'h0; m_exp_pc = 32'h0; prev_redirect = 0; n_req = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("idle_no_req", imem_req_valid, 0);
  endtask

  task automatic cycle();
    logic        rv;
    logic [31:0] rd;
    int unsigned outst;
    @(negedge clk);
    cyc++;
    rv = 0;
    rd = $urandom;
    if (mem_q.size() > 0 && mem_q[0].rc <= cyc && $urandom_range(99, 0) < rsp_pct) begin
      rv = 1;
      rd = ifn(mem_q[0].addr);
    end
    imem_rsp_valid = rv; imem_rsp_data = rd;
    imem_req_ready = t_ready; out_ready = t_out_ready;
    redirect_valid = t_redirect; redirect_pc = t_redirect_pc; halt_req = t_halt;
    #1;
    outst = mem_q.size();
    chk("buf_le_depth", 64'(buf_count <= 3'(DEPTH)), 1);
    if (prev_redirect) chk("ov_after_redirect", out_valid, 0);
    if (halted) chk("halted_outstanding", outst, 0);
    if (imem_req_valid) begin
      chk("req_addr", imem_req_addr, m_fetch_pc);
      chk("credit", 64'((outst + buf_count) < DEPTH), 1);
      chk("req_while_halt", halt_req, 0);
    end
    if (out_valid && out_ready) begin
      chk("out_pc", out_pc, m_exp_pc);
      chk("out_instr", out_instr, ifn(m_exp_pc));
      pops_log.push_back(out_pc);
      n_pops++;
      m_exp_pc = m_exp_pc + 32'd4;
    end
    if (rv) begin
      void'(mem_q.pop_front());
      last_rsp_cyc = cyc;
    end
    if (imem_req_valid && imem_req_ready) begin
      mem_q.push_back('{addr: imem_req_addr, rc: cyc + $urandom_range(lat_max, lat_min)});
      req_log.push_back(imem_req_addr);
      n_req++;
    end
    if (redirect_valid) begin
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
      m_exp_pc   = {redirect_pc[31:2], 2'b00};
      req_log.delete();
      pops_log.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    prev_redirect = redirect_valid;
    obs_req_valid = imem_req_valid;
    obs_halted    = halted;
    obs_count     = buf_count;
    t_redirect    = 0;
  endtask

  initial begin
    int unsigned p0;
    reset = 1'b0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    redirect_valid = 0; redirect_pc = '0; halt_req = 0; out_ready = 0;

    // Streaming: one instruction per cycle in order
    do_reset();
    lat_min = 1; lat_max = 1; rsp_pct = 100; t_ready = 1; t_out_ready = 1;
    repeat (10) cycle();
    p0 = n_pops;
    repeat (10) cycle();
    chk("stream_rate", n_pops - p0, 10);
    chk("stream_pc0", pops_log.size() > 0 ? pops_log[0] : 32'hdead, 32'h0);
    chk("stream_pc1", pops_log.size() > 1 ? pops_log[1] : 32'hdead, 32'h4);

    // Back-pressure fills exactly DEPTH slots
    do_reset();
    t_ready = 1; t_out_ready = 0;
    repeat (12) cycle();
    chk("full_nreq", n_req, DEPTH);
    chk("full_count", obs_count, DEPTH);
    chk("full_no_req", obs_req_valid, 0);
    t_out_ready = 1; cycle(); t_out_ready = 0;
    cycle();
    chk("full_req_after_pop", obs_req_valid, 1);

    // Redirect with three outstanding requests
    do_reset();
    lat_min = 5; lat_max = 5; t_ready = 1; t_out_ready = 1;
    for (int i = 0; i < 20 && mem_q.size() < 3; i++) cycle();
    chk("rd_outst3", mem_q.size(), 3);
    t_ready = 0; t_redirect = 1; t_redirect_pc = 32'h103;
    cycle();
    t_ready = 1;
    repeat (30) cycle();
    chk("rd_first_req", req_log.size() > 0 ? req_log[0] : 32'hdead, 32'h100);
    chk("rd_first_pop", pops_log.size() > 0 ? pops_log[0] : 32'hdead, 32'h100);

    // Address wrap at the top of the space
    lat_min = 1; lat_max = 1;
    t_redirect = 1; t_redirect_pc = 32'hFFFF_FFFC;
    cycle();
    repeat (10) cycle();
    chk("wrap_req0", req_log.size() > 1 ? req_log[0] : 32'hdead, 32'hFFFF_FFFC);
    chk("wrap_req1", req_log.size() > 1 ? req_log[1] : 32'hdead, 32'h0);
    chk("wrap_pop1", pops_log.size() > 1 ? pops_log[1] : 32'hdead, 32'h0);

    // Halt with two outstanding requests
    do_reset();
    lat_min = 4; lat_max = 4; t_ready = 1; t_out_ready = 0;
    for (int i = 0; i < 20 && mem_q.size() < 2; i++) cycle();
    chk("halt_outst2", mem_q.size(), 2);
    t_halt = 1;
    obs_halted = 0;
    for (int i = 0; i < 30 && !obs_halted; i++) cycle();
    chk("halt_seen", obs_halted, 1);
    chk("halt_timing", cyc, last_rsp_cyc + 1);
    t_out_ready = 1;
    pops_log.delete();
    repeat (4) cycle();
    chk("halt_drain", pops_log.size(), 2);
    chk("halt_stay", obs_halted, 1);
    t_halt = 0;
    req_log.delete();
    for (int i = 0; i < 10 && req_log.size() == 0; i++) cycle();
    chk("resume_pc", req_log.size() > 0 ? req_log[0] : 32'hdead, 32'h8);

    // Randomized traffic, with a reset part-way through
    p0 = n_pops;
    lat_min = 1; lat_max = 4; rsp_pct = 70;
    for (int phase = 0; phase < 2; phase++) begin
      do_reset();
      for (int i = 0; i < 5000; i++) begin
        t_ready     = ($urandom_range(99, 0) < 75);
        t_out_ready = ($urandom_range(99, 0) < 65);
        if ($urandom_range(99, 0) < 3) begin
          t_redirect    = 1;
          t_redirect_pc = ($urandom_range(9, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                      : 32'($urandom_range(1023, 0));
        end
        if (!t_halt && $urandom_range(999, 0) < 5) t_halt = 1;
        else if (t_halt && $urandom_range(99, 0) < 5) t_halt = 0;
        cycle();
      end
    end
    chk("random_progress", 64'((n_pops - p0) > 1000), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter XLEN, default 32: PC and address width, 32 or 64.
REQ-002 Parameter DEPTH, default 4: instruction buffer entries; power of 2, 2 to 16.
REQ-003 Parameter RESET_PC, default 0: first fetch address, word aligned.
REQ-004 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Port imem_req_valid  out  1  fetch request valid.
REQ-007 Port imem_req_addr  out  XLEN  fetch byte address.
REQ-008 Port imem_req_ready  in  1  memory accepts the request.
REQ-009 Port imem_rsp_valid  in  1  response data valid; responses return in order, at least 1 cycle after acceptance.
REQ-010 Port imem_rsp_data  in  32  instruction word.
REQ-011 Port redirect_valid  in  1  branch/jump redirect strobe.
REQ-012 Port redirect_pc  in  XLEN  redirect target.
REQ-013 Port halt_req  in  1  level request to stop fetching.
REQ-014 Port halted  out  1  fetch stopped, no requests outstanding.
REQ-015 Port out_valid  out  1  buffered instruction available.
REQ-016 Port out_ready  in  1  decode stage consumes the instruction.
REQ-017 Port out_instr  out  32  head instruction.
REQ-018 Port out_pc  out  XLEN  address of the head instruction.
REQ-019 Port buf_count  out  $clog2(DEPTH+1)  current buffer occupancy.

Function
REQ-020 The FSM SHALL have states IDLE, RUN, HALTING and HALTED; IDLE holds for one cycle after reset release, then moves to RUN.
REQ-021 In RUN, imem_req_valid SHALL be 1 only when outstanding + buf_count < DEPTH (credit rule), so the buffer can never overflow.
REQ-022 imem_req_addr SHALL equal fetch_pc; on each accepted request (valid && ready) fetch_pc SHALL advance by 4, wrapping modulo 2^XLEN.
REQ-023 While valid and not ready, the request address SHALL remain stable, unless a redirect occurs.
REQ-024 Each accepted request SHALL push its address into an in-order tag queue; each kept response SHALL write {tag address, data} into the buffer.
REQ-025 out_instr and out_pc SHALL come combinationally from the buffer head; an entry is popped on out_valid && out_ready.
REQ-026 Simultaneous push and pop SHALL leave buf_count unchanged; the same holds at full and at empty when a response bypasses the head.
REQ-027 On redirect_valid: the buffer SHALL be cleared, fetch_pc SHALL load {redirect_pc[XLEN-1:2], 2'b00}, and the discard counter SHALL load the outstanding count, including a request accepted in the same cycle.
REQ-028 While discard > 0, each response SHALL be dropped and the counter decremented; a response arriving in the redirect cycle itself SHALL also be dropped.
REQ-029 A pop in the redirect cycle SHALL complete normally; out_valid SHALL be 0 in the following cycle.
REQ-030 A request SHALL be issuable in the cycle after a redirect, subject to REQ-021 using the post-flush counts.
REQ-031 halt_req in RUN SHALL move the FSM to HALTING and deassert imem_req_valid; HALTING SHALL move to HALTED when outstanding == 0.
REQ-032 halted SHALL be 1 only in HALTED; the buffer SHALL still drain to out_ready while in HALTED.
REQ-033 Deassertion of halt_req in HALTING or HALTED SHALL return the FSM to RUN.
REQ-034 A redirect in HALTING or HALTED SHALL update fetch_pc and the discard counter but SHALL NOT leave the state.
REQ-035 The outstanding and discard counters SHALL saturate-check: the RTL SHALL carry an assertion that neither exceeds DEPTH.

Reset
REQ-036 Asserting reset low SHALL immediately produce: FSM IDLE, fetch_pc = RESET_PC, buffer empty, outstanding = 0, discard = 0.
REQ-037 During reset, outputs SHALL be: imem_req_valid 0, out_valid 0, halted 0, buf_count 0.
REQ-038 Reset mid-transaction SHALL abandon in-flight requests; responses arriving after reset release SHALL NOT be expected by the memory model.

Verification
REQ-039 Reset release, ready=1, 1-cycle response latency, out_ready=1 -> out_pc sequence 0x0, 0x4, 0x8, ... with one instruction per cycle in steady state.
REQ-040 DEPTH=4, out_ready=0 -> exactly 4 requests issued, buf_count=4, imem_req_valid=0 until the first pop.
REQ-041 Redirect to 0x103 with 3 requests outstanding -> next request address 0x100, 3 responses dropped, first out_pc=0x100.
REQ-042 fetch_pc=0xFFFFFFFC (XLEN=32) accepted -> next request address 0x00000000.
REQ-043 halt_req with 2 requests outstanding -> halted asserts in the cycle after the 2nd response; buffered entries are still delivered; halt_req low resumes fetch at the next PC.
REQ-044 Random ready/response latency/out_ready/redirect, 10k cycles versus a reference model -> no overflow, no lost or duplicated instruction, out_pc matches the model.
